// File: rtl/banco_registradores_param_pkg.sv
// Shared defaults and helpers for the parametrised register file.
package banco_registradores_param_pkg;

  localparam int DATA_W_PADRAO = 8;
  localparam int ADDR_W_PADRAO = 3;

  // Base bit of port 'porta' inside a flat vector of 'largura'-bit fields.
  function automatic int baseFatia(input int porta, input int largura);
    return porta * largura;
  endfunction

endpackage

// File: rtl/banco_registradores_param_if.sv
// Register-file bus: read ports, write port, reservation port and status.
interface banco_registradores_param_if
  import banco_registradores_param_pkg::*;
  #(
    parameter int DATA_W = DATA_W_PADRAO,
    parameter int ADDR_W = ADDR_W_PADRAO,
    parameter int N_READ = 2
  );

  logic [N_READ*ADDR_W-1:0] RegLido;
  logic [N_READ*DATA_W-1:0] Dado;
  logic [N_READ-1:0]        Pendente;
  logic                     RegWrite;
  logic [ADDR_W-1:0]        RegEscr;
  logic [DATA_W-1:0]        DadoEscr;
  logic                     Reserve;
  logic [ADDR_W-1:0]        RegReserv;
  logic                     ReserveErr;
  logic [ADDR_W:0]          NumPendentes;

  modport master (
    output RegLido, RegWrite, RegEscr, DadoEscr, Reserve, RegReserv,
    input  Dado, Pendente, ReserveErr, NumPendentes
  );

  modport slave (
    input  RegLido, RegWrite, RegEscr, DadoEscr, Reserve, RegReserv,
    output Dado, Pendente, ReserveErr, NumPendentes
  );

endinterface

// File: rtl/banco_registradores_param_placar_pendencias.sv
// Pending scoreboard: one bit per register, set by reservations and
// cleared by writes. A write and a reservation to the same register on the
// same edge leave it pending (producer hand-off), without an error.
module placar_pendencias #(
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     set,
  input  logic [ADDR_W-1:0]        setAddr,
  input  logic                     clear,
  input  logic [ADDR_W-1:0]        clearAddr,
  output logic [(1<<ADDR_W)-1:0]   pendente,
  output logic [(1<<ADDR_W)-1:0]   pendenteProx,
  output logic                     ReserveErr,
  output logic [ADDR_W:0]          NumPendentes
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic           setEf;
  logic           clrEf;
  logic           erroProx;
  logic [ADDR_W:0] contaProx;

  // Post-edge pending vector, refusal flag and population count.
  always_comb begin
    setEf        = set && !(ZR && setAddr == '0);
    clrEf        = clear && !(ZR && clearAddr == '0);
    erroProx     = setEf && pendente[setAddr] && !(clrEf && clearAddr == setAddr);
    pendenteProx = pendente;
    if (clrEf) pendenteProx[clearAddr] = 1'b0;
    if (setEf) pendenteProx[setAddr] = 1'b1;
    contaProx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      contaProx = contaProx + (ADDR_W+1)'(pendenteProx[i]);
    end
  end

  // Scoreboard state and registered status outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pendente     <= '0;
      ReserveErr   <= 1'b0;
      NumPendentes <= '0;
    end else begin
      pendente     <= pendenteProx;
      ReserveErr   <= erroProx;
      NumPendentes <= contaProx;
    end
  end

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised register file: registered multi-port reads with optional
// write-to-read bypass, optional hardwired zero register, and a pending
// scoreboard for multi-cycle producers.
module banco_registradores_param
  import banco_registradores_param_pkg::*;
  #(
    parameter int DATA_W   = DATA_W_PADRAO,
    parameter int ADDR_W   = ADDR_W_PADRAO,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
  ) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    banco_registradores_param_if.slave  bus
  );

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] banco [DEPTH];
  logic [DEPTH-1:0]  pendente;
  logic [DEPTH-1:0]  pendenteProx;
  logic              escrEf;
  logic [ADDR_W-1:0] enderLido [N_READ];
  logic [DATA_W-1:0] dadoQ [N_READ];
  logic [N_READ-1:0] pendQ;

  assign escrEf = bus.RegWrite && !(ZR && bus.RegEscr == '0);

  placar_pendencias #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) uPlacar (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .set          (bus.Reserve),
    .setAddr      (bus.RegReserv),
    .clear        (bus.RegWrite),
    .clearAddr    (bus.RegEscr),
    .pendente     (pendente),
    .pendenteProx (pendenteProx),
    .ReserveErr   (bus.ReserveErr),
    .NumPendentes (bus.NumPendentes)
  );

  // Unpack read addresses and pack read data onto the flat bus vectors.
  always_comb begin
    bus.Dado = '0;
    for (int p = 0; p < N_READ; p++) begin
      enderLido[p] = bus.RegLido[baseFatia(p, ADDR_W) +: ADDR_W];
      bus.Dado[baseFatia(p, DATA_W) +: DATA_W] = dadoQ[p];
    end
  end

  assign bus.Pendente = pendQ;

  // Storage array write port.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) banco[i] <= '0;
    end else if (escrEf) begin
      banco[bus.RegEscr] <= bus.DadoEscr;
    end
  end

  // Registered read ports; with bypass they see the post-edge data and pending state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < N_READ; p++) dadoQ[p] <= '0;
      pendQ <= '0;
    end else begin
      for (int p = 0; p < N_READ; p++) begin
        if (ZR && enderLido[p] == '0) begin
          dadoQ[p] <= '0;
          pendQ[p] <= 1'b0;
        end else if (BYP) begin
          dadoQ[p] <= (escrEf && bus.RegEscr == enderLido[p]) ? bus.DadoEscr
                                                               : banco[enderLido[p]];
          pendQ[p] <= pendenteProx[enderLido[p]];
        end else begin
          dadoQ[p] <= banco[enderLido[p]];
          pendQ[p] <= pendente[enderLido[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_banco_registradores_param.sv
// Bench for banco_registradores_param: two instances share one stimulus
// stream, one with bypass and no zero register, one with a zero register
// and no bypass. Each is compared against an array-based reference model.
module tb_banco_registradores_param;

  logic       Clock;
  logic       Reset_n;
  logic [5:0] regLido;
  logic       regWrite;
  logic [2:0] regEscr;
  logic [7:0] dadoEscr;
  logic       reserve;
  logic [2:0] regReserv;

  int vetores;
  int miscompares;

  banco_registradores_param_if #(.DATA_W(8), .ADDR_W(3), .N_READ(2)) bus0();
  banco_registradores_param_if #(.DATA_W(8), .ADDR_W(3), .N_READ(2)) bus1();

  assign bus0.RegLido   = regLido;
  assign bus0.RegWrite  = regWrite;
  assign bus0.RegEscr   = regEscr;
  assign bus0.DadoEscr  = dadoEscr;
  assign bus0.Reserve   = reserve;
  assign bus0.RegReserv = regReserv;
  assign bus1.RegLido   = regLido;
  assign bus1.RegWrite  = regWrite;
  assign bus1.RegEscr   = regEscr;
  assign bus1.DadoEscr  = dadoEscr;
  assign bus1.Reserve   = reserve;
  assign bus1.RegReserv = regReserv;

  banco_registradores_param #(
    .DATA_W(8), .ADDR_W(3), .N_READ(2), .ZERO_REG(0), .BYPASS(1)
  ) dut0 (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus0)
  );

  banco_registradores_param #(
    .DATA_W(8), .ADDR_W(3), .N_READ(2), .ZERO_REG(1), .BYPASS(0)
  ) dut1 (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: index 0 = bypass/no zero reg, index 1 = zero reg/no bypass.
  logic [7:0] mMod [2][8];
  bit         pMod [2][8];
  logic [7:0] eDado [2][2];
  bit         ePend [2][2];
  bit         eErr [2];
  int         eNum [2];

  task automatic zeraModelo();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 8; r++) begin
        mMod[c][r] = 8'h00;
        pMod[c][r] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        eDado[c][i] = 8'h00;
        ePend[c][i] = 1'b0;
      end
      eErr[c] = 1'b0;
      eNum[c] = 0;
    end
  endtask

  task automatic modelo();
    bit         zr, byp, wEf, rEf;
    logic [7:0] mNovo [8];
    bit         pNovo [8];
    logic [2:0] a;
    for (int c = 0; c < 2; c++) begin
      zr  = (c == 1);
      byp = (c == 0);
      wEf = regWrite && !(zr && regEscr == 3'd0);
      rEf = reserve && !(zr && regReserv == 3'd0);
      for (int r = 0; r < 8; r++) begin
        mNovo[r] = mMod[c][r];
        pNovo[r] = pMod[c][r];
      end
      eErr[c] = rEf && pMod[c][regReserv] && !(wEf && regEscr == regReserv);
      if (wEf) begin
        mNovo[regEscr] = dadoEscr;
        pNovo[regEscr] = 1'b0;
      end
      if (rEf) pNovo[regReserv] = 1'b1;
      for (int i = 0; i < 2; i++) begin
        a = regLido[i*3 +: 3];
        if (zr && a == 3'd0) begin
          eDado[c][i] = 8'h00;
          ePend[c][i] = 1'b0;
        end else if (byp) begin
          eDado[c][i] = mNovo[a];
          ePend[c][i] = pNovo[a];
        end else begin
          eDado[c][i] = mMod[c][a];
          ePend[c][i] = pMod[c][a];
        end
      end
      eNum[c] = 0;
      for (int r = 0; r < 8; r++) begin
        eNum[c] += int'(pNovo[r]);
        mMod[c][r] = mNovo[r];
        pMod[c][r] = pNovo[r];
      end
    end
  endtask

  task automatic confere(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    vetores++;
    if (atual !== esperado) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic confereModelo(input string tag);
    confere({tag, " d0.dado0"}, 32'(bus0.Dado[7:0]),  32'(eDado[0][0]));
    confere({tag, " d0.dado1"}, 32'(bus0.Dado[15:8]), 32'(eDado[0][1]));
    confere({tag, " d0.pend"},  32'(bus0.Pendente),   32'({ePend[0][1], ePend[0][0]}));
    confere({tag, " d0.err"},   32'(bus0.ReserveErr), 32'(eErr[0]));
    confere({tag, " d0.num"},   32'(bus0.NumPendentes), 32'(eNum[0]));
    confere({tag, " d1.dado0"}, 32'(bus1.Dado[7:0]),  32'(eDado[1][0]));
    confere({tag, " d1.dado1"}, 32'(bus1.Dado[15:8]), 32'(eDado[1][1]));
    confere({tag, " d1.pend"},  32'(bus1.Pendente),   32'({ePend[1][1], ePend[1][0]}));
    confere({tag, " d1.err"},   32'(bus1.ReserveErr), 32'(eErr[1]));
    confere({tag, " d1.num"},   32'(bus1.NumPendentes), 32'(eNum[1]));
  endtask

  task automatic confereZero(input string tag);
    confere({tag, " d0.dado"}, 32'(bus0.Dado),         32'h0);
    confere({tag, " d0.pend"}, 32'(bus0.Pendente),     32'h0);
    confere({tag, " d0.err"},  32'(bus0.ReserveErr),   32'h0);
    confere({tag, " d0.num"},  32'(bus0.NumPendentes), 32'h0);
    confere({tag, " d1.dado"}, 32'(bus1.Dado),         32'h0);
    confere({tag, " d1.num"},  32'(bus1.NumPendentes), 32'h0);
  endtask

  task automatic passo(input bit w, input logic [2:0] we, input logic [7:0] wd,
                       input bit r, input logic [2:0] rr,
                       input logic [2:0] l0, input logic [2:0] l1, input string tag);
    regWrite  = w;
    regEscr   = we;
    dadoEscr  = wd;
    reserve   = r;
    regReserv = rr;
    regLido   = {l1, l0};
    @(posedge Clock);
    modelo();
    #1;
    confereModelo(tag);
  endtask

  typedef struct {
    bit         w;
    logic [2:0] we;
    logic [7:0] wd;
    bit         r;
    logic [2:0] rr;
    logic [2:0] l0;
    logic [2:0] l1;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         p0;
    bit         p1;
    bit         err;
    int         num;
    logic [7:0] e1d0;
    bit         e1p0;
    bit         e1err;
  } vetor_t;

  vetor_t tab [11];

  initial begin
    vetores     = 0;
    miscompares = 0;

    //          w we  wd     r rr l0 l1  d0     d1     p0 p1 er num e1d0  e1p e1e
    tab[0]  = '{0, 0, 8'h00, 0, 0, 3, 3, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0};
    tab[1]  = '{1, 3, 8'hA5, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0};
    tab[2]  = '{0, 0, 8'h00, 0, 0, 3, 3, 8'hA5, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0};
    tab[3]  = '{1, 5, 8'h3C, 0, 0, 5, 3, 8'h3C, 8'hA5, 0, 0, 0, 0, 8'h00, 0, 0};
    tab[4]  = '{0, 0, 8'h00, 1, 2, 2, 2, 8'h00, 8'h00, 1, 1, 0, 1, 8'h00, 0, 0};
    tab[5]  = '{0, 0, 8'h00, 1, 2, 2, 5, 8'h00, 8'h3C, 1, 0, 1, 1, 8'h00, 1, 1};
    tab[6]  = '{0, 0, 8'h00, 0, 0, 2, 2, 8'h00, 8'h00, 1, 1, 0, 1, 8'h00, 1, 0};
    tab[7]  = '{1, 2, 8'h11, 0, 0, 2, 2, 8'h11, 8'h11, 0, 0, 0, 0, 8'h00, 1, 0};
    tab[8]  = '{1, 2, 8'h22, 1, 2, 2, 3, 8'h22, 8'hA5, 1, 0, 0, 1, 8'h11, 0, 0};
    tab[9]  = '{1, 0, 8'hFF, 1, 0, 0, 2, 8'hFF, 8'h22, 1, 1, 0, 2, 8'h00, 0, 0};
    tab[10] = '{0, 0, 8'h00, 0, 0, 0, 5, 8'hFF, 8'h3C, 1, 0, 0, 2, 8'h00, 0, 0};

    regWrite  = 1'b0;
    regEscr   = 3'd0;
    dadoEscr  = 8'h00;
    reserve   = 1'b0;
    regReserv = 3'd0;
    regLido   = 6'd0;
    Reset_n   = 1'b0;
    zeraModelo();
    #2;
    confereZero("reset.inicial");
    @(negedge Clock);
    Reset_n = 1'b1;

    for (int a = 0; a < 8; a++) begin
      passo(0, 3'd0, 8'h00, 0, 3'd0, 3'(a), 3'(7 - a), $sformatf("reset.leitura%0d", a));
      confere($sformatf("reset.leitura%0d.dado", a), 32'(bus0.Dado), 32'h0);
    end

    for (int k = 0; k < 11; k++) begin
      passo(tab[k].w, tab[k].we, tab[k].wd, tab[k].r, tab[k].rr,
            tab[k].l0, tab[k].l1, $sformatf("tab%0d", k));
      confere($sformatf("tab%0d.dado0", k), 32'(bus0.Dado[7:0]),    32'(tab[k].d0));
      confere($sformatf("tab%0d.dado1", k), 32'(bus0.Dado[15:8]),   32'(tab[k].d1));
      confere($sformatf("tab%0d.pend", k),  32'(bus0.Pendente),     32'({tab[k].p1, tab[k].p0}));
      confere($sformatf("tab%0d.err", k),   32'(bus0.ReserveErr),   32'(tab[k].err));
      confere($sformatf("tab%0d.num", k),   32'(bus0.NumPendentes), 32'(tab[k].num));
      confere($sformatf("tab%0d.z.dado0", k), 32'(bus1.Dado[7:0]),  32'(tab[k].e1d0));
      confere($sformatf("tab%0d.z.pend0", k), 32'(bus1.Pendente[0]), 32'(tab[k].e1p0));
      confere($sformatf("tab%0d.z.err", k),   32'(bus1.ReserveErr), 32'(tab[k].e1err));
    end

    for (int n = 0; n < 400; n++) begin
      passo(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)),
            ($urandom_range(2, 0) == 0), 3'($urandom_range(7, 0)),
            3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), $sformatf("rand%0d", n));
    end

    passo(0, 3'd0, 8'h00, 1, 3'd1, 3'd1, 3'd4, "resv.r1");
    passo(0, 3'd0, 8'h00, 1, 3'd4, 3'd1, 3'd4, "resv.r4");
    passo(0, 3'd0, 8'h00, 1, 3'd6, 3'd6, 3'd4, "resv.r6");
    regWrite = 1'b0;
    reserve  = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    zeraModelo();
    confereZero("reset.assinc");
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      passo(0, 3'd0, 8'h00, 0, 3'd0, 3'(a), 3'(a), $sformatf("posreset%0d", a));
      confere($sformatf("posreset%0d.dado", a), 32'(bus0.Dado), 32'h0);
      confere($sformatf("posreset%0d.num", a),  32'(bus0.NumPendentes), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vetores, miscompares);
    $finish;
  end

endmodule
